// File: rtl/conv1d_stride_engine.sv
// conv1d_stride_engine: streaming 1-D convolution with configurable kernel
// size (KSIZE) and window advance (STRIDE).
// A frame is: header L, then KSIZE weights (w0 first), then L samples.
// Results come out of a two-stage multiply / sum pipeline.
// Build option CONV_SATURATE_EN: clamp each result to the 16-bit signed
// range instead of keeping the low 16 bits.
module conv1d_stride_engine #(
  parameter int KSIZE  = 2,
  parameter int STRIDE = 2
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic signed [15:0] x_in,
  input  logic               x_en,
  output logic               in_ready,
  output logic signed [15:0] y_out,
  output logic               y_valid,
  output logic        [15:0] out_count,
  output logic               out_count_valid,
  output logic               done
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int PROD_W = DATA_W + COEF_W;
  // Three guard bits hold the sum of up to eight full-scale products.
  localparam int ACC_W  = PROD_W + 3;
  localparam int WIDX_W = 3;

  localparam logic [15:0]       KSIZE_U   = 16'(KSIZE);
  localparam logic [15:0]       STRIDE_U  = 16'(STRIDE);
  localparam logic [3:0]        PH_RELOAD = 4'(STRIDE - 1);
  localparam logic [WIDX_W-1:0] WLAST     = WIDX_W'(KSIZE - 1);

  typedef enum logic [1:0] {IDLE, WLOAD, RUN, FLUSH} state_t;

  state_t state_q, state_d;

  logic [15:0]       len_q;
  logic [WIDX_W-1:0] widx_q;
  logic [15:0]       sample_cnt_q;
  logic [3:0]        ph_q;

  logic signed [COEF_W-1:0] wgt_q  [KSIZE];
  logic signed [DATA_W-1:0] win_q  [KSIZE];
  logic signed [DATA_W-1:0] win_p0 [KSIZE];
  logic signed [PROD_W-1:0] prod_p1 [KSIZE];
  logic signed [ACC_W-1:0]  acc_p1;
  logic                     vld_p1;
  logic                     vld_p2;

  logic accept;
  logic hdr_acc;
  logic wgt_acc;
  logic run_acc;
  logic full_p0;
  logic fire_p0;
  logic last_p0;

  // Number of windows a frame of l samples produces.
  function automatic logic [15:0] count_results(input logic [15:0] l);
    if (l >= KSIZE_U) return ((l - KSIZE_U) / STRIDE_U) + 16'd1;
    return 16'd0;
  endfunction

  // Full-precision signed tap product.
  function automatic logic signed [PROD_W-1:0] mul_tap(
    input logic signed [COEF_W-1:0] w,
    input logic signed [DATA_W-1:0] x
  );
    logic signed [PROD_W-1:0] we;
    logic signed [PROD_W-1:0] xe;
    we = {{(PROD_W-COEF_W){w[COEF_W-1]}}, w};
    xe = {{(PROD_W-DATA_W){x[DATA_W-1]}}, x};
    return we * xe;
  endfunction

  // Reduce the accumulator to the 16-bit output word.
  function automatic logic signed [DATA_W-1:0] fit16(input logic signed [ACC_W-1:0] a);
`ifdef CONV_SATURATE_EN
    if (a > $signed(ACC_W'(32767)))  return 16'sh7FFF;
    if (a < $signed(ACC_W'(-32768))) return 16'sh8000;
    return DATA_W'(a);
`else
    return DATA_W'(a);
`endif
  endfunction

  assign accept  = x_en && in_ready;
  assign hdr_acc = accept && (state_q == IDLE);
  assign wgt_acc = accept && (state_q == WLOAD);
  assign run_acc = accept && (state_q == RUN);
  // The window is full once this accept brings the count to KSIZE or more.
  assign full_p0 = (sample_cnt_q >= (KSIZE_U - 16'd1));
  assign fire_p0 = run_acc && full_p0 && (ph_q == 4'd0);
  assign last_p0 = ((sample_cnt_q + 16'd1) == len_q);

  // State register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and Moore outputs
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b1;
    done     = 1'b0;
    case (state_q)
      IDLE:  if (x_en) state_d = WLOAD;
      WLOAD: if (x_en && (widx_q == WLAST)) state_d = (len_q != 16'd0) ? RUN : FLUSH;
      RUN:   if (x_en && last_p0) state_d = FLUSH;
      FLUSH: begin
        in_ready = 1'b0;
        if (!vld_p1 && !vld_p2) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame bookkeeping: length, weight index, sample count, stride phase, result count
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      len_q           <= '0;
      widx_q          <= '0;
      sample_cnt_q    <= '0;
      ph_q            <= '0;
      out_count       <= '0;
      out_count_valid <= 1'b0;
    end else begin
      out_count_valid <= 1'b0;
      if (hdr_acc) begin
        len_q           <= $unsigned(x_in);
        out_count       <= count_results($unsigned(x_in));
        out_count_valid <= 1'b1;
        widx_q          <= '0;
        sample_cnt_q    <= '0;
        ph_q            <= '0;
      end
      if (wgt_acc) widx_q <= widx_q + 1'b1;
      if (run_acc) begin
        sample_cnt_q <= sample_cnt_q + 16'd1;
        // ph_q counts the accepts still to go before the next window fires.
        if (full_p0) ph_q <= (ph_q == 4'd0) ? PH_RELOAD : (ph_q - 4'd1);
      end
    end
  end

  // Window as it will look after the current accept (x0 oldest)
  always_comb begin
    for (int k = 0; k < KSIZE - 1; k++) win_p0[k] = win_q[k + 1];
    win_p0[KSIZE-1] = x_in;
  end

  // Weight and sample window storage
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int k = 0; k < KSIZE; k++) begin
        wgt_q[k] <= '0;
        win_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < KSIZE; k++) begin
        if (wgt_acc && (widx_q == WIDX_W'(k))) wgt_q[k] <= x_in;
        if (hdr_acc)      win_q[k] <= '0;
        else if (run_acc) win_q[k] <= win_p0[k];
      end
    end
  end

  // ---- stage p0 -> p1: per-tap products of the firing window
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      vld_p1 <= 1'b0;
      for (int k = 0; k < KSIZE; k++) prod_p1[k] <= '0;
    end else begin
      vld_p1 <= fire_p0;
      if (fire_p0) begin
        for (int k = 0; k < KSIZE; k++) prod_p1[k] <= mul_tap(wgt_q[k], win_p0[k]);
      end
    end
  end

  // Sign-extended sum of the registered products
  always_comb begin
    acc_p1 = '0;
    for (int k = 0; k < KSIZE; k++)
      acc_p1 = acc_p1 + {{(ACC_W-PROD_W){prod_p1[k][PROD_W-1]}}, prod_p1[k]};
  end

  // ---- stage p1 -> p2: registered sum, reduced to 16 bits
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      vld_p2 <= 1'b0;
      y_out  <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) y_out <= fit16(acc_p1);
    end
  end

  assign y_valid = vld_p2;

endmodule

// File: tb/tb_conv1d_stride_engine.sv
// tb_conv1d_stride_engine: two engines (KSIZE=2/STRIDE=2 and KSIZE=3/STRIDE=1)
// driven with directed and random frames; expected results come from a
// window-by-window arithmetic model of the frame.
module tb_conv1d_stride_engine;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  logic signed [15:0] x_in_s      [2];
  logic               x_en_s      [2];
  logic               in_ready_s  [2];
  logic signed [15:0] y_out_s     [2];
  logic               y_valid_s   [2];
  logic        [15:0] out_count_s [2];
  logic               ocv_s       [2];
  logic               done_s      [2];

  conv1d_stride_engine #(.KSIZE(2), .STRIDE(2)) dut_a (
    .ACLK(clk), .ARESET(rst), .x_in(x_in_s[0]), .x_en(x_en_s[0]),
    .in_ready(in_ready_s[0]), .y_out(y_out_s[0]), .y_valid(y_valid_s[0]),
    .out_count(out_count_s[0]), .out_count_valid(ocv_s[0]), .done(done_s[0])
  );

  conv1d_stride_engine #(.KSIZE(3), .STRIDE(1)) dut_b (
    .ACLK(clk), .ARESET(rst), .x_in(x_in_s[1]), .x_en(x_en_s[1]),
    .in_ready(in_ready_s[1]), .y_out(y_out_s[1]), .y_valid(y_valid_s[1]),
    .out_count(out_count_s[1]), .out_count_valid(ocv_s[1]), .done(done_s[1])
  );

  always #5 clk = ~clk;

  // Cycle index used to time-stamp accepts and output pulses
  always @(posedge clk) cyc <= cyc + 1;

`ifdef CONV_SATURATE_EN
  localparam int BIG_Y = 32767;
`else
  localparam int BIG_Y = 2;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int act = 0;

  int fr_w[$];
  int fr_s[$];
  int last_y[$];

  int yv_cyc[$];
  int yv_val[$];
  int oc_cyc[$];
  int oc_val[$];
  int dn_cyc[$];
  int dn_rdy[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ks_of(input int sel);
    return (sel == 0) ? 2 : 3;
  endfunction

  function automatic int st_of(input int sel);
    return (sel == 0) ? 2 : 1;
  endfunction

  function automatic int fit16(input longint a);
`ifdef CONV_SATURATE_EN
    if (a > 32767)  return 32767;
    if (a < -32768) return -32768;
    return int'(a);
`else
    logic signed [15:0] lo;
    lo = 16'(a);
    return int'(lo);
`endif
  endfunction

  function automatic int rnd16();
    case ($urandom_range(0, 7))
      0:       return 32767;
      1:       return -32768;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  // Output monitor for the engine currently under test
  always @(negedge clk) begin
    if (y_valid_s[act]) begin
      yv_cyc.push_back(cyc);
      yv_val.push_back(int'(y_out_s[act]));
    end
    if (ocv_s[act]) begin
      oc_cyc.push_back(cyc);
      oc_val.push_back(int'(out_count_s[act]));
    end
    if (done_s[act]) begin
      dn_cyc.push_back(cyc);
      dn_rdy.push_back(int'(in_ready_s[act]));
    end
  end

  task automatic clear_mon();
    yv_cyc = {}; yv_val = {}; oc_cyc = {}; oc_val = {}; dn_cyc = {}; dn_rdy = {};
  endtask

  // Drive one frame (header L, fr_w, fr_s) into engine sel and check it.
  // stop_at >= 0 stops right after driving that word index (no checks).
  task automatic run_frame(input int sel, input int L, input bit gaps, input int stop_at);
    int words[$];
    int acc_cyc[$];
    int exp_y[$];
    int k;
    int s;
    bit ok;
    k = ks_of(sel);
    s = st_of(sel);
    words.push_back(L);
    foreach (fr_w[i]) words.push_back(fr_w[i]);
    foreach (fr_s[i]) words.push_back(fr_s[i]);
    // Reference: a window ends at every sample count n = k, k+s, k+2s, ... <= L
    for (int n = k; n <= L; n += s) begin
      longint acc;
      acc = 0;
      for (int t = 0; t < k; t++) acc += longint'(fr_w[t]) * longint'(fr_s[n - k + t]);
      exp_y.push_back(fit16(acc));
    end

    @(posedge clk); #1;
    act = sel;
    clear_mon();

    for (int i = 0; i < words.size(); i++) begin
      ok = 1'b0;
      for (int g = 0; g < 60 && !ok; g++) begin
        @(negedge clk);
        if (gaps && $urandom_range(0, 3) == 0) begin
          x_en_s[sel] = 1'b0;
          x_in_s[sel] = 16'($urandom);
        end else begin
          x_en_s[sel] = 1'b1;
          x_in_s[sel] = 16'(words[i]);
          ok = in_ready_s[sel];
        end
      end
      if (!ok) begin
        chk("in_ready_timeout", 0, 1);
        x_en_s[sel] = 1'b0;
        return;
      end
      acc_cyc.push_back(cyc);
      if (stop_at >= 0 && i == stop_at) return;
    end

    // Junk offered while flushing must be ignored; stop offering once done shows.
    ok = 1'b0;
    for (int g = 0; g < 40 && !ok; g++) begin
      @(negedge clk);
      if (done_s[sel]) begin
        ok = 1'b1;
        x_en_s[sel] = 1'b0;
      end else begin
        x_en_s[sel] = 1'($urandom_range(0, 1));
        x_in_s[sel] = 16'($urandom);
      end
    end
    x_en_s[sel] = 1'b0;
    if (!ok) chk("done_timeout", 0, 1);
    repeat (4) @(negedge clk);

    chk("oc_pulses", oc_cyc.size(), 1);
    if (oc_cyc.size() > 0) begin
      chk("oc_cycle", oc_cyc[0], acc_cyc[0] + 1);
      chk("oc_value", oc_val[0], exp_y.size());
    end
    chk("oc_hold", int'(out_count_s[sel]), exp_y.size());
    chk("y_pulses", yv_val.size(), exp_y.size());
    for (int j = 0; j < exp_y.size() && j < yv_val.size(); j++) begin
      int n;
      n = k + j * s;
      chk("y_value", yv_val[j], exp_y[j]);
      chk("y_latency", yv_cyc[j] - acc_cyc[k + n], 2);
    end
    chk("done_pulses", dn_cyc.size(), 1);
    if (dn_cyc.size() > 0) begin
      chk("done_in_ready", dn_rdy[0], 0);
      if (yv_cyc.size() > 0) chk("done_after_y", int'(dn_cyc[0] > yv_cyc[yv_cyc.size()-1]), 1);
    end
    last_y = yv_val;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      x_en_s[i] = 1'b0;
      x_in_s[i] = '0;
    end
    #1;
    chk("rst_in_ready",  int'(in_ready_s[0]),  1);
    chk("rst_y_out",     int'(y_out_s[0]),     0);
    chk("rst_y_valid",   int'(y_valid_s[0]),   0);
    chk("rst_out_count", int'(out_count_s[0]), 0);
    chk("rst_ocv",       int'(ocv_s[0]),       0);
    chk("rst_done",      int'(done_s[0]),      0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic stride-2 frame
    fr_w = {1, 1}; fr_s = {1, 2, 3, 4};
    run_frame(0, 4, 1'b0, -1);
    chk("d35_n", last_y.size(), 2);
    if (last_y.size() == 2) begin
      chk("d35_y0", last_y[0], 3);
      chk("d35_y1", last_y[1], 7);
    end

    // Reset in the middle of a frame, just after the first sample
    run_frame(0, 4, 1'b0, 3);
    @(posedge clk); #2;
    x_en_s[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_y_out",     int'(y_out_s[0]),     0);
    chk("arst_y_valid",   int'(y_valid_s[0]),   0);
    chk("arst_out_count", int'(out_count_s[0]), 0);
    chk("arst_ocv",       int'(ocv_s[0]),       0);
    chk("arst_done",      int'(done_s[0]),      0);
    chk("arst_in_ready",  int'(in_ready_s[0]),  1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    clear_mon();
    repeat (8) @(negedge clk);
    chk("arst_no_y",    yv_val.size(), 0);
    chk("arst_no_done", dn_cyc.size(), 0);
    run_frame(0, 4, 1'b0, -1);
    chk("arst_n", last_y.size(), 2);
    if (last_y.size() == 2) begin
      chk("arst_y0", last_y[0], 3);
      chk("arst_y1", last_y[1], 7);
    end

    // Odd length: trailing sample does not fire
    fr_s = {1, 2, 3, 4, 5};
    run_frame(0, 5, 1'b0, -1);
    chk("d36_n", last_y.size(), 2);

    // Empty frame, then a single-window frame
    fr_w = {1, 1}; fr_s = {};
    run_frame(0, 0, 1'b0, -1);
    fr_w = {2, 3}; fr_s = {5, 7};
    run_frame(0, 2, 1'b0, -1);
    chk("d37_n", last_y.size(), 1);
    if (last_y.size() == 1) chk("d37_y", last_y[0], 31);

    // Overflow of the 16-bit result
    fr_w = {32767, 32767}; fr_s = {32767, 32767};
    run_frame(0, 2, 1'b0, -1);
    chk("d38_n", last_y.size(), 1);
    if (last_y.size() == 1) chk("d38_y", last_y[0], BIG_Y);

    // Three taps, stride 1
    fr_w = {1, 1, 1}; fr_s = {1, 2, 3, 4};
    run_frame(1, 4, 1'b0, -1);
    chk("d39_n", last_y.size(), 2);
    if (last_y.size() == 2) begin
      chk("d39_y0", last_y[0], 6);
      chk("d39_y1", last_y[1], 9);
    end

    // Random frames on both engines, with idle cycles in the input stream
    for (int r = 0; r < 24; r++) begin
      int sel;
      int L;
      sel = r % 2;
      L = $urandom_range(0, 12);
      fr_w = {};
      fr_s = {};
      for (int t = 0; t < ks_of(sel); t++) fr_w.push_back(rnd16());
      for (int t = 0; t < L; t++) fr_s.push_back(rnd16());
      run_frame(sel, L, 1'($urandom_range(0, 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
